// File: rtl/i2c_slave_target.sv
// I2C target: synchronises the bus, decodes START/STOP and the 7-bit address,
// ACKs matching writes, keeps the last written byte and returns it on reads.
// Reset is synchronous and active-high.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus free or not addressed since reset/STOP
// ADDR     | shifting in 7 address bits + R/W
// ADDR_ACK | address matched, driving the ACK bit
// WR_BYTE  | shifting in a write data byte
// WR_ACK   | driving the ACK bit after a write byte
// RD_BYTE  | shifting saved_data out, MSB first
// RD_ACK   | sampling the master's ACK/NACK after a read byte
// IGNORE   | not for us, or master NACKed; wait for START or STOP
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       right_address,
    output logic       check_data,
    output logic       read_data,
    output logic [7:0] saved_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_BYTE  = 3'd3,
        WR_ACK   = 3'd4,
        RD_BYTE  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    state_t                 state_q, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]             shreg_q, shreg_nxt;
    logic [7:0]             saved_q, saved_nxt;
    logic [2:0]             bit_cnt_q, bit_cnt_nxt;
    logic                   rw_q, rw_nxt;
    // ACK states: set once the ACK bit is being driven (or, in RD_ACK, once the master ACKed)
    logic                   ack_phase_q, ack_phase_nxt;
    logic                   sda_oe_nxt, read_nxt, busy_nxt, ra_nxt, cd_nxt;
    logic                   last_bit, addr_match;

    // Bus synchronisers plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '0;
            sda_sync <= '0;
            scl_d    <= 1'b0;
            sda_d    <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_det  = scl_s & sda_d & ~sda_s;
    assign stop_det   = scl_s & ~sda_d & sda_s;
    assign last_bit   = (bit_cnt_q == 3'd7);
    assign addr_match = (shreg_q[6:0] == SLAVE_ADDR);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= 8'h00;
            saved_q       <= 8'h00;
            bit_cnt_q     <= 3'd0;
            rw_q          <= 1'b0;
            ack_phase_q   <= 1'b0;
            sda_oe        <= 1'b0;
            read_data     <= 1'b0;
            busy          <= 1'b0;
            right_address <= 1'b0;
            check_data    <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            shreg_q       <= shreg_nxt;
            saved_q       <= saved_nxt;
            bit_cnt_q     <= bit_cnt_nxt;
            rw_q          <= rw_nxt;
            ack_phase_q   <= ack_phase_nxt;
            sda_oe        <= sda_oe_nxt;
            read_data     <= read_nxt;
            busy          <= busy_nxt;
            right_address <= ra_nxt;
            check_data    <= cd_nxt;
        end
    end

    // Next-state decode; START/STOP override any data edge
    always_comb begin
        state_nxt = state_q;
        if (start_det) begin
            state_nxt = ADDR;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (scl_rise && last_bit) state_nxt = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall && ack_phase_q) state_nxt = rw_q ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (scl_rise && last_bit) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall && ack_phase_q) state_nxt = WR_BYTE;
                RD_BYTE:  if (scl_fall && bit_cnt_q == 3'd0) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s)           state_nxt = IGNORE;
                    else if (scl_fall && ack_phase_q) state_nxt = RD_BYTE;
                end
                default: state_nxt = state_q;
            endcase
        end
    end

    // Datapath and output next values; sda_oe only moves on SCL falling edges
    always_comb begin
        shreg_nxt     = shreg_q;
        saved_nxt     = saved_q;
        bit_cnt_nxt   = bit_cnt_q;
        rw_nxt        = rw_q;
        ack_phase_nxt = ack_phase_q;
        sda_oe_nxt    = sda_oe;
        read_nxt      = read_data;
        busy_nxt      = busy;
        ra_nxt        = 1'b0;
        cd_nxt        = 1'b0;
        if (start_det) begin
            bit_cnt_nxt   = 3'd0;
            ack_phase_nxt = 1'b0;
            busy_nxt      = 1'b1;
            read_nxt      = 1'b0;
            sda_oe_nxt    = 1'b0;
        end else if (stop_det) begin
            bit_cnt_nxt   = 3'd0;
            ack_phase_nxt = 1'b0;
            busy_nxt      = 1'b0;
            read_nxt      = 1'b0;
            sda_oe_nxt    = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shreg_nxt   = {shreg_q[6:0], sda_s};
                    bit_cnt_nxt = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        rw_nxt        = sda_s;
                        ra_nxt        = addr_match;
                        ack_phase_nxt = 1'b0;
                    end
                end
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!ack_phase_q) begin
                        sda_oe_nxt    = 1'b1;
                        ack_phase_nxt = 1'b1;
                    end else begin
                        ack_phase_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            shreg_nxt  = saved_q;
                            sda_oe_nxt = ~saved_q[7];
                            read_nxt   = 1'b1;
                        end else begin
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shreg_nxt   = {shreg_q[6:0], sda_s};
                    bit_cnt_nxt = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        saved_nxt     = {shreg_q[6:0], sda_s};
                        cd_nxt        = 1'b1;
                        ack_phase_nxt = 1'b0;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_nxt    = 1'b0;
                            ack_phase_nxt = 1'b0;
                        end else begin
                            sda_oe_nxt = ~shreg_q[6];
                            shreg_nxt  = {shreg_q[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && !sda_s) begin
                        ack_phase_nxt = 1'b1;
                    end else if (scl_fall && ack_phase_q) begin
                        ack_phase_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd0;
                        shreg_nxt     = saved_q;
                        sda_oe_nxt    = ~saved_q[7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign saved_data = saved_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: an open-drain bus model with a bit-banged
// master driving write, mismatch, read, partial-byte, repeated-START and reset cases.
module tb_i2c_slave_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, right_address, check_data, read_data, busy;
    logic [7:0] saved_data;

    int errors = 0;
    int checks = 0;
    int ra_cnt = 0;
    int cd_cnt = 0;
    int oe_cnt = 0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_target #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .scl_in        (scl_m),
        .sda_in        (sda_line),
        .sda_oe        (sda_oe),
        .right_address (right_address),
        .check_data    (check_data),
        .read_data     (read_data),
        .saved_data    (saved_data),
        .busy          (busy)
    );

    // Event counters for pulses and for cycles with SDA pulled low
    always @(posedge clk) begin
        if (right_address) ra_cnt <= ra_cnt + 1;
        if (check_data)    cd_cnt <= cd_cnt + 1;
        if (sda_oe)        oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wq(Q);
        scl_m = 1'b1; wq(2 * Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        b = sda_line; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         ra0, cd0, oe0;

        // Power-on reset
        wq(5);
        rst = 1'b0;
        wq(5);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read_data", 32'(read_data), 32'd0);
        check("rst_saved", 32'(saved_data), 32'h00);

        // Write 0xA5 to 0x50
        ra0 = ra_cnt; cd0 = cd_cnt;
        i2c_start;
        check("wr_busy_after_start", 32'(busy), 32'd1);
        write_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 32'd0);
        check("wr_saved", 32'(saved_data), 32'hA5);
        i2c_stop;
        wq(4);
        check("wr_busy_after_stop", 32'(busy), 32'd0);
        check("wr_ra_pulses", 32'(ra_cnt - ra0), 32'd1);
        check("wr_cd_pulses", 32'(cd_cnt - cd0), 32'd1);

        // Address 0x51: must be ignored
        ra0 = ra_cnt; oe0 = oe_cnt;
        i2c_start;
        write_byte(8'hA2, ack);
        check("mis_addr_nack", 32'(ack), 32'd1);
        check("mis_state_ignore", 32'(dut.state_q), 32'd7);
        write_byte(8'h00, ack);
        check("mis_data_nack", 32'(ack), 32'd1);
        check("mis_still_ignore", 32'(dut.state_q), 32'd7);
        i2c_stop;
        wq(4);
        check("mis_no_ra", 32'(ra_cnt - ra0), 32'd0);
        check("mis_sda_never_low", 32'(oe_cnt - oe0), 32'd0);
        check("mis_saved", 32'(saved_data), 32'hA5);

        // Write 0x3C, then read it back twice (ACK then NACK)
        i2c_start;
        write_byte(8'hA0, ack);
        write_byte(8'h3C, ack);
        i2c_stop;
        check("rd_pre_saved", 32'(saved_data), 32'h3C);
        i2c_start;
        write_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        check("rd_read_data_hi", 32'(read_data), 32'd1);
        read_byte(rd, 1'b0);
        check("rd_byte1", 32'(rd), 32'h3C);
        read_byte(rd, 1'b1);
        check("rd_byte2", 32'(rd), 32'h3C);
        check("rd_read_data_after_nack", 32'(read_data), 32'd1);
        i2c_stop;
        wq(4);
        check("rd_read_data_after_stop", 32'(read_data), 32'd0);

        // Partial byte followed by STOP is discarded
        cd0 = cd_cnt;
        i2c_start;
        write_byte(8'hA0, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop;
        wq(4);
        check("part_no_cd", 32'(cd_cnt - cd0), 32'd0);
        check("part_saved", 32'(saved_data), 32'h3C);
        check("part_state_idle", 32'(dut.state_q), 32'd0);

        // Write 0x11, repeated START, read it back
        ra0 = ra_cnt;
        i2c_start;
        write_byte(8'hA0, ack);
        write_byte(8'h11, ack);
        check("rs_saved", 32'(saved_data), 32'h11);
        i2c_start;
        write_byte(8'hA1, ack);
        check("rs_addr_ack", 32'(ack), 32'd0);
        read_byte(rd, 1'b1);
        check("rs_read", 32'(rd), 32'h11);
        i2c_stop;
        wq(4);
        check("rs_ra_pulses", 32'(ra_cnt - ra0), 32'd2);

        // Reset while the target is driving the address ACK
        i2c_start;
        for (int i = 7; i >= 0; i--) write_bit(i == 5 || i == 7);
        check("rstm_oe_before", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstm_oe_next_clk", 32'(sda_oe), 32'd0);
        wq(3);
        check("rstm_saved", 32'(saved_data), 32'h00);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_read_data", 32'(read_data), 32'd0);
        rst = 1'b0;
        i2c_stop;
        wq(4);
        check("rstm_state_idle", 32'(dut.state_q), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
